// File: rtl/sample_gain_stage.sv
// ============================================================================
// Module   : sample_gain_stage
// Purpose  : Programmable gain about mid-scale (0x80) for unsigned 8-bit
//            samples. The result saturates to 0x00..0xFF and clipped samples
//            are flagged and counted. 3-stage valid/ready pipeline.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_gain_stage #(
  parameter int         GAIN_FRAC = 6,
  parameter logic [7:0] GAIN_RST  = 8'h40,
  parameter int         SATCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          gain_in,
  input  logic                gain_wr,
  output logic [7:0]          out_data,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SATCNT_W-1:0] sat_cnt,
  input  logic                sat_clr
);

  localparam logic [SATCNT_W-1:0] c_SAT_MAX = '1;

  logic [7:0]          r_gain;
  logic                r_s1_valid;
  logic signed [8:0]   r_s1_d;
  logic [7:0]          r_s1_gain;
  logic                r_s2_valid;
  logic signed [16:0]  r_s2_p;
  logic                r_s3_valid;
  logic [7:0]          r_out_data;
  logic                r_out_sat;
  logic [SATCNT_W-1:0] r_sat_cnt;

  logic                w_s3_adv;
  logic                w_s3_load;
  logic                w_s2_adv;
  logic                w_s2_load;
  logic                w_s1_adv;
  logic                w_in_fire;
  logic signed [8:0]   w_d;
  logic signed [16:0]  w_p;
  logic signed [16:0]  w_shift;
  logic signed [10:0]  w_s;
  logic [7:0]          w_clamp;
  logic                w_clip;

  // A stage may load when empty or when its occupant moves on this cycle.
  assign w_s3_adv  = r_s3_valid && out_ready;
  assign w_s3_load = !r_s3_valid || w_s3_adv;
  assign w_s2_adv  = r_s2_valid && w_s3_load;
  assign w_s2_load = !r_s2_valid || w_s2_adv;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_in_fire = in_valid && in_ready;

  assign w_d     = $signed({1'b0, in_data}) - 9'sd128;
  assign w_p     = $signed({{8{r_s1_d[8]}}, r_s1_d}) * $signed({9'b0, r_s1_gain});
  assign w_shift = r_s2_p >>> GAIN_FRAC;
  assign w_s     = $signed(w_shift[10:0]) + 11'sd128;

  always_comb begin
    w_clamp = w_s[7:0];
    w_clip  = 1'b0;
    if (w_s[10]) begin
      w_clamp = 8'h00;
      w_clip  = 1'b1;
    end else if (w_s[9:8] != 2'b00) begin
      w_clamp = 8'hFF;
      w_clip  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gain <= GAIN_RST;
    end else if (gain_wr) begin
      r_gain <= gain_in;
    end
  end

  // The gain snapshot is taken from the register before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_d     <= '0;
      r_s1_gain  <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_fire) begin
        r_s1_d    <= w_d;
        r_s1_gain <= r_gain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_p     <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_s2_p <= w_p;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s3_valid <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (w_s3_load) begin
      r_s3_valid <= r_s2_valid;
      if (w_s2_adv) begin
        r_out_data <= w_clamp;
        r_out_sat  <= w_clip;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_s3_adv && r_out_sat && (r_sat_cnt != c_SAT_MAX)) begin
      r_sat_cnt <= r_sat_cnt + 1'b1;
    end
  end

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = r_s3_valid;
  assign sat_cnt   = r_sat_cnt;

endmodule

`default_nettype wire
